// File: rtl/countdown_timer.sv
// Loadable down-counting timer with prescaled decrement, pause/resume and
// optional auto-reload; done pulses for one cycle after the terminal decrement.
module countdown_timer #(
  parameter int WIDTH    = 10,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] reload_reg;
  logic [PW-1:0]    prescaler;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      prescaler  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count      <= load_value;
        reload_reg <= load_value;
        prescaler  <= '0;
        state      <= IDLE;
      end else if (stop) begin
        if (state == RUN) state <= PAUSED;
      end else if (start && state != RUN) begin
        // Resume from PAUSED keeps the prescaler phase; a fresh start restarts it.
        if (count != '0) begin
          if (state == IDLE) prescaler <= '0;
          state <= RUN;
        end
      end else if (state == RUN) begin
        if (prescaler == PRE_LAST) begin
          prescaler <= '0;
          if (count > WIDTH'(1)) begin
            count <= count - WIDTH'(1);
          end else begin
            done <= 1'b1;
            if (auto_reload) begin
              count <= reload_reg;
            end else begin
              count <= '0;
              state <= IDLE;
            end
          end
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end
    end
  end

  assign busy   = (state == RUN);
  assign paused = (state == PAUSED);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: PRESCALE=1 and PRESCALE=4 instances share stimulus
// and are checked every cycle against a behavioural model, plus directed scenarios.
module tb_countdown_timer;

  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset, load, start, stop, auto_reload;
  logic [W-1:0] load_value;
  logic [W-1:0] count1, count4;
  logic         busy1, paused1, done1, busy4, paused4, done4;

  always #5 clock = ~clock;

  countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .count(count1), .busy(busy1), .paused(paused1), .done(done1)
  );

  countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .count(count4), .busy(busy4), .paused(paused4), .done(done4)
  );

  typedef struct {
    int cnt;
    int rld;
    int phase;
    bit running;
    bit held;
    bit done;
  } mdl_t;

  mdl_t m1, m4;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the timer as seen from outside: phase counts cycles spent
  // running modulo the prescale, and a decrement happens when it wraps.
  function automatic mdl_t step(input mdl_t m, input int ps);
    mdl_t n = m;
    n.done = 0;
    if (reset) begin
      n = '{0, 0, 0, 0, 0, 0};
    end else if (load) begin
      n.cnt = int'(load_value); n.rld = int'(load_value);
      n.phase = 0; n.running = 0; n.held = 0;
    end else if (stop) begin
      if (m.running) begin n.running = 0; n.held = 1; end
    end else if (start && !m.running) begin
      if (m.cnt != 0) begin
        if (!m.held) n.phase = 0;
        n.running = 1; n.held = 0;
      end
    end else if (m.running) begin
      n.phase = (m.phase + 1) % ps;
      if (n.phase == 0) begin
        if (m.cnt > 1) n.cnt = m.cnt - 1;
        else begin
          n.done = 1;
          if (auto_reload) n.cnt = m.rld;
          else begin n.cnt = 0; n.running = 0; end
        end
      end
    end
    return n;
  endfunction

  task automatic cycle();
    @(posedge clock);
    m1 = step(m1, 1);
    m4 = step(m4, 4);
    #1;
    check("cnt1", count1, m1.cnt);
    check("busy1", busy1, m1.running);
    check("paused1", paused1, m1.held);
    check("done1", done1, m1.done);
    check("cnt4", count4, m4.cnt);
    check("busy4", busy4, m4.running);
    check("paused4", paused4, m4.held);
    check("done4", done4, m4.done);
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = W'(v);
    cycle();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    int exp_seq[6] = '{2, 1, 3, 2, 1, 3};
    m1 = '{0, 0, 0, 0, 0, 0};
    m4 = '{0, 0, 0, 0, 0, 0};
    reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; load_value = '0;
    cycle();
    cycle();
    reset = 1'b0;

    // Scenario 1: basic countdown 5 -> 0.
    do_load(5);
    do_start();
    check("s1_busy_after_start", busy1, 1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("s1_cnt", count1, 4 - i);
      check("s1_done", done1, (i == 4));
      check("s1_busy", busy1, (i != 4));
    end
    cycle();
    check("s1_done_one_cycle", done1, 0);

    // Scenario 2: auto-reload periodic ticks.
    auto_reload = 1'b1;
    do_load(3);
    do_start();
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("s2_cnt", count1, exp_seq[i]);
      check("s2_done", done1, (exp_seq[i] == 3));
      check("s2_busy", busy1, 1);
    end
    auto_reload = 1'b0;
    do_load(0);

    // Scenario 3: pause at 2, hold, resume.
    do_load(6);
    do_start();
    repeat (4) cycle();
    check("s3_cnt_before_stop", count1, 2);
    stop = 1'b1; cycle(); stop = 1'b0;
    repeat (4) cycle();
    check("s3_cnt_held", count1, 2);
    check("s3_paused", paused1, 1);
    do_start();
    cycle();
    check("s3_cnt_resume", count1, 1);
    cycle();
    check("s3_cnt_end", count1, 0);
    check("s3_done", done1, 1);

    // Scenario 4: reload mid-run aborts without done.
    do_load(9);
    do_start();
    repeat (5) cycle();
    check("s4_cnt_before", count1, 4);
    do_load(7);
    check("s4_cnt_loaded", count1, 7);
    check("s4_idle", busy1, 0);
    repeat (3) cycle();

    // Scenario 5: start with zero, start+stop from idle, reset mid-run.
    do_load(0);
    do_start();
    check("s5_zero_start", busy1, 0);
    do_load(3);
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    check("s5_start_stop", busy1, 0);
    do_start();
    cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    check("s5_rst_cnt", count1, 0);
    check("s5_rst_busy", busy1, 0);
    check("s5_rst_cnt4", count4, 0);

    // Scenario 6: PRESCALE=4 instance.
    do_load(2);
    do_start();
    repeat (3) cycle();
    check("s6_cnt_pre3", count4, 2);
    cycle();
    check("s6_cnt_4", count4, 1);
    repeat (4) cycle();
    check("s6_cnt_8", count4, 0);
    check("s6_done_8", done4, 1);

    // Randomised traffic, including max load values.
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      load        = ($urandom_range(0, 29) == 0);
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 19) == 0);
      auto_reload = $urandom_range(0, 1);
      load_value  = ($urandom_range(0, 39) == 0) ? W'((1 << W) - 1) : W'($urandom_range(0, 12));
      cycle();
    end
    reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
